// File: rtl/mult_div_unit.sv
// Iterative MIPS multiply/divide unit: shift-add MULT/MULTU and restoring DIV/DIVU,
// one result bit per cycle, results held in architectural HI/LO registers.
module mult_div_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             Start,
    input  logic [1:0]       Op,
    input  logic [WIDTH-1:0] Operand_A,
    input  logic [WIDTH-1:0] Operand_B,
    input  logic             HI_Write,
    input  logic             LO_Write,
    input  logic [WIDTH-1:0] Write_Data,
    output logic             Busy,
    output logic             Done,
    output logic             DivByZero,
    output logic [WIDTH-1:0] HI,
    output logic [WIDTH-1:0] LO
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_FIX
    } state_t;

    state_t             r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_is_div;
    logic               r_signed_op;
    logic               r_sign_a;
    logic               r_sign_b;
    logic               r_b_zero;
    logic [WIDTH-1:0]   r_opnd;
    logic [WIDTH-1:0]   r_a_raw;
    logic [2*WIDTH-1:0] r_acc;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;
    logic               r_done;
    logic               r_dbz;

    // Operand conditioning at the Start edge: magnitudes for signed ops, raw values otherwise.
    logic               w_op_signed;
    logic               w_sign_a;
    logic               w_sign_b;
    logic [WIDTH-1:0]   w_mag_a;
    logic [WIDTH-1:0]   w_mag_b;

    assign w_op_signed = ~Op[0];
    assign w_sign_a    = w_op_signed & Operand_A[WIDTH-1];
    assign w_sign_b    = w_op_signed & Operand_B[WIDTH-1];
    assign w_mag_a     = w_sign_a ? -Operand_A : Operand_A;
    assign w_mag_b     = w_sign_b ? -Operand_B : Operand_B;

    // Shift-add step: multiplier sits in the low half and is consumed LSB first.
    logic [WIDTH:0]     w_add;
    logic [WIDTH:0]     w_sum;
    logic [2*WIDTH-1:0] w_mul_next;

    assign w_add      = r_acc[0] ? {1'b0, r_opnd} : '0;
    assign w_sum      = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + w_add;
    assign w_mul_next = {w_sum, r_acc[WIDTH-1:1]};

    // Restoring step: the shifted remainder needs one extra bit before the trial subtract.
    logic [WIDTH:0]     w_rem_sh;
    logic [WIDTH:0]     w_trial;
    logic               w_ge;
    logic [2*WIDTH-1:0] w_div_next;

    assign w_rem_sh   = {r_acc[2*WIDTH-1:WIDTH], r_acc[WIDTH-1]};
    assign w_trial    = w_rem_sh - {1'b0, r_opnd};
    assign w_ge       = (w_rem_sh >= {1'b0, r_opnd});
    assign w_div_next = w_ge ? {w_trial[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b1}
                             : {w_rem_sh[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b0};

    // Sign fix-up and divide-by-zero override applied on the final edge.
    logic [2*WIDTH-1:0] w_prod_neg;
    logic [WIDTH-1:0]   w_fix_hi;
    logic [WIDTH-1:0]   w_fix_lo;

    assign w_prod_neg = -r_acc;

    always_comb begin
        w_fix_hi = r_acc[2*WIDTH-1:WIDTH];
        w_fix_lo = r_acc[WIDTH-1:0];
        if (r_is_div) begin
            if (r_b_zero) begin
                w_fix_hi = r_a_raw;
                w_fix_lo = '1;
            end else if (r_signed_op) begin
                w_fix_lo = (r_sign_a ^ r_sign_b) ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0];
                w_fix_hi = r_sign_a ? -r_acc[2*WIDTH-1:WIDTH] : r_acc[2*WIDTH-1:WIDTH];
            end
        end else if (r_signed_op && (r_sign_a ^ r_sign_b)) begin
            w_fix_hi = w_prod_neg[2*WIDTH-1:WIDTH];
            w_fix_lo = w_prod_neg[WIDTH-1:0];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_is_div    <= 1'b0;
            r_signed_op <= 1'b0;
            r_sign_a    <= 1'b0;
            r_sign_b    <= 1'b0;
            r_b_zero    <= 1'b0;
            r_opnd      <= '0;
            r_a_raw     <= '0;
            r_acc       <= '0;
            r_hi        <= '0;
            r_lo        <= '0;
            r_done      <= 1'b0;
            r_dbz       <= 1'b0;
        end else begin
            r_done <= 1'b0;
            r_dbz  <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (HI_Write) r_hi <= Write_Data;
                    if (LO_Write) r_lo <= Write_Data;
                    if (Start) begin
                        r_is_div    <= Op[1];
                        r_signed_op <= w_op_signed;
                        r_sign_a    <= w_sign_a;
                        r_sign_b    <= w_sign_b;
                        r_b_zero    <= (Operand_B == '0);
                        r_a_raw     <= Operand_A;
                        r_cnt       <= '0;
                        // Multiply: multiplicand kept aside, multiplier in the low half.
                        // Divide: divisor kept aside, dividend in the low half.
                        r_opnd      <= Op[1] ? w_mag_b : w_mag_a;
                        r_acc       <= {{WIDTH{1'b0}}, (Op[1] ? w_mag_a : w_mag_b)};
                        r_state     <= S_CALC;
                    end
                end
                S_CALC: begin
                    r_acc <= r_is_div ? w_div_next : w_mul_next;
                    if (r_cnt == CNT_W'(WIDTH - 1)) begin
                        r_state <= S_FIX;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                S_FIX: begin
                    r_hi    <= w_fix_hi;
                    r_lo    <= w_fix_lo;
                    r_done  <= 1'b1;
                    r_dbz   <= r_is_div & r_b_zero;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign Busy      = (r_state != S_IDLE);
    assign Done      = r_done;
    assign DivByZero = r_dbz;
    assign HI        = r_hi;
    assign LO        = r_lo;

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed bench for mult_div_unit: expected results are queued at issue and
// checked by an independent monitor whenever Done pulses.
module tb_mult_div_unit;

    logic        clk;
    logic        rst;
    logic        Start;
    logic [1:0]  Op;
    logic [31:0] Operand_A;
    logic [31:0] Operand_B;
    logic        HI_Write;
    logic        LO_Write;
    logic [31:0] Write_Data;
    logic        Busy;
    logic        Done;
    logic        DivByZero;
    logic [31:0] HI;
    logic [31:0] LO;

    int checks = 0;
    int errors = 0;

    logic [64:0] exp_q[$];
    string       name_q[$];

    localparam logic [1:0] OP_MULT = 2'b00, OP_MULTU = 2'b01, OP_DIV = 2'b10, OP_DIVU = 2'b11;

    mult_div_unit #(.WIDTH(32), .CNT_W(5)) dut (
        .clk(clk), .rst(rst), .Start(Start), .Op(Op),
        .Operand_A(Operand_A), .Operand_B(Operand_B),
        .HI_Write(HI_Write), .LO_Write(LO_Write), .Write_Data(Write_Data),
        .Busy(Busy), .Done(Done), .DivByZero(DivByZero), .HI(HI), .LO(LO)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end else begin
            $display("ok   %s value=%h", name, act);
        end
    endtask

    // Monitor: pops one expected result per Done pulse.
    always @(negedge clk) begin
        logic [64:0] e;
        string       n;
        if (!rst) begin
            if (Done) begin
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_done actual=HI:%h LO:%h required=no Done", HI, LO);
                end else begin
                    e = exp_q.pop_front();
                    n = name_q.pop_front();
                    chk({n, ".HI"}, HI, e[64:33]);
                    chk({n, ".LO"}, LO, e[32:1]);
                    chk({n, ".DivByZero"}, {31'd0, DivByZero}, {31'd0, e[0]});
                end
            end else if (DivByZero) begin
                errors++;
                $display("FAIL stray_divbyzero actual=1 required=0");
            end
        end
    end

    task automatic run_op(input string name, input logic [1:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] ehi, input logic [31:0] elo,
                          input logic edbz, input bit disturb, input bit same_edge_hw);
        int  cycles;
        bit  done_seen;
        exp_q.push_back({ehi, elo, edbz});
        name_q.push_back(name);
        Start     = 1'b1;
        Op        = op;
        Operand_A = a;
        Operand_B = b;
        if (same_edge_hw) begin
            HI_Write   = 1'b1;
            Write_Data = 32'h0000_5555;
        end
        @(negedge clk);
        Start     = 1'b0;
        HI_Write  = 1'b0;
        Operand_A = 32'hA5A5_A5A5;
        Operand_B = 32'h5A5A_5A5A;
        if (same_edge_hw) chk({name, ".same_edge_HI_Write"}, HI, 32'h0000_5555);
        cycles    = 0;
        done_seen = 1'b0;
        for (int t = 0; t < 100; t++) begin
            if (Done) begin
                done_seen = 1'b1;
                break;
            end
            if (Busy) cycles++;
            if (disturb && cycles == 5) begin
                Start      = 1'b1;
                Operand_A  = 32'd9;
                LO_Write   = 1'b1;
                Write_Data = 32'h0000_DEAD;
            end else if (disturb && cycles == 6) begin
                Start    = 1'b0;
                LO_Write = 1'b0;
            end
            @(negedge clk);
        end
        Start    = 1'b0;
        LO_Write = 1'b0;
        chk({name, ".done_seen"}, {31'd0, done_seen}, 32'd1);
        chk({name, ".busy_cycles"}, cycles, 32'd33);
    endtask

    initial begin
        rst        = 1'b1;
        Start      = 1'b0;
        Op         = 2'b00;
        Operand_A  = '0;
        Operand_B  = '0;
        HI_Write   = 1'b0;
        LO_Write   = 1'b0;
        Write_Data = '0;
        repeat (2) @(negedge clk);
        chk("reset.Busy", {31'd0, Busy}, 32'd0);
        chk("reset.Done", {31'd0, Done}, 32'd0);
        chk("reset.DivByZero", {31'd0, DivByZero}, 32'd0);
        chk("reset.HI", HI, 32'd0);
        chk("reset.LO", LO, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        run_op("multu_max", OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0, 0, 0);
        run_op("mult_neg3x7", OP_MULT, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0, 0, 0);
        run_op("mult_min_sq", OP_MULT, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 1'b0, 0, 0);
        run_op("div_neg7by2", OP_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, 0, 0);
        run_op("div_7byneg2", OP_DIV, 32'd7, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, 1'b0, 0, 0);
        run_op("div_overflow", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 1'b0, 0, 0);
        run_op("divu_100by7", OP_DIVU, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0, 0, 0);
        run_op("div_neg8by0", OP_DIV, 32'hFFFF_FFF8, 32'd0, 32'hFFFF_FFF8, 32'hFFFF_FFFF, 1'b1, 0, 0);
        run_op("divu_5by0", OP_DIVU, 32'd5, 32'd0, 32'd5, 32'hFFFF_FFFF, 1'b1, 0, 0);
        @(negedge clk);
        chk("divu_5by0.dbz_next_cycle", {31'd0, DivByZero}, 32'd0);
        chk("divu_5by0.done_next_cycle", {31'd0, Done}, 32'd0);

        // Asynchronous reset during CALC abandons the operation.
        Start     = 1'b1;
        Op        = OP_MULTU;
        Operand_A = 32'h0000_1234;
        Operand_B = 32'h0000_0010;
        @(negedge clk);
        Start = 1'b0;
        repeat (9) @(negedge clk);
        chk("midreset.busy_before", {31'd0, Busy}, 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("midreset.Busy", {31'd0, Busy}, 32'd0);
        chk("midreset.Done", {31'd0, Done}, 32'd0);
        chk("midreset.HI", HI, 32'd0);
        chk("midreset.LO", LO, 32'd0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (40) @(negedge clk);
        run_op("multu_4x5", OP_MULTU, 32'd4, 32'd5, 32'd0, 32'd20, 1'b0, 0, 0);

        // MTHI in IDLE, then disturbances during CALC.
        HI_Write   = 1'b1;
        Write_Data = 32'h0000_1234;
        @(negedge clk);
        HI_Write = 1'b0;
        chk("idle_mthi.HI", HI, 32'h0000_1234);
        run_op("multu_2x3_disturbed", OP_MULTU, 32'd2, 32'd3, 32'd0, 32'd6, 1'b0, 1, 1);

        repeat (40) @(negedge clk);
        chk("scoreboard_empty", exp_q.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
